// File: rtl/factorial_seq_ctrl.sv
// Iterative factorial sequencer: one operand in, n! plus a sticky overflow flag out,
// using a single shared multiplier that performs one multiply per clock.
module factorial_seq_ctrl #(
  parameter int N_W   = 4,
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_W-1:0]   in_num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_fact,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic [N_W:0]       cnt_q, cnt_d;
  logic [N_W-1:0]     num_q, num_d;
  logic               ovf_q, ovf_d;
  logic [2*RES_W-1:0] prod;

  // Full-width product so the bits above RES_W can feed the overflow flag.
  function automatic logic [2*RES_W-1:0] mul_full(input logic [RES_W-1:0] a,
                                                   input logic [N_W:0]     b);
    logic [2*RES_W-1:0] wa;
    logic [2*RES_W-1:0] wb;
    wa = (2*RES_W)'(a);
    wb = (2*RES_W)'(b);
    return wa * wb;
  endfunction

  function automatic logic hi_nonzero(input logic [2*RES_W-1:0] p);
    return |p[2*RES_W-1:RES_W];
  endfunction

  assign prod = mul_full(acc_q, cnt_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          num_d   = in_num;
          acc_d   = RES_W'(1);
          cnt_d   = (N_W+1)'(2);
          ovf_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        // cnt carries one extra bit, so stepping past num_q never wraps.
        if (cnt_q > {1'b0, num_q}) begin
          state_d = DONE;
        end else begin
          acc_d = prod[RES_W-1:0];
          ovf_d = ovf_q | hi_nonzero(prod);
          cnt_d = cnt_q + (N_W+1)'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= RES_W'(1);
      cnt_q   <= '0;
      num_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_fact  = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_factorial_seq_ctrl.sv
// Scoreboard bench for factorial_seq_ctrl: directed and random operands checked
// against a plain-arithmetic factorial model, with a decoupled output monitor.
module tb_factorial_seq_ctrl;
  localparam int N_W   = 4;
  localparam int RES_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N_W-1:0]   in_num;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_fact;
  logic             out_ovf;
  logic             busy;

  factorial_seq_ctrl #(.N_W(N_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fact(out_fact), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RES_W-1:0] fact;
    logic             ovf;
    int               n;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_rise = -100;
  int   rdy_mode = 0;   // 0: always ready, 1: stall, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic longint unsigned fact_ref(input int n);
    longint unsigned f = 1;
    for (int i = 2; i <= n; i++) f = f * longint'(i);
    return f;
  endfunction

  // Offer operand n; acc_cyc returns the index of the accepting clock edge.
  task automatic send(input int n, input bit scramble, input bit keep, output int acc_cyc);
    int t = 0;
    exp_t e;
    longint unsigned f;
    in_valid = 1'b1;
    in_num   = N_W'(n);
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      acc_cyc  = -1;
      return;
    end
    acc_cyc = cyc + 1;
    f = fact_ref(n);
    e.fact = f[RES_W-1:0];
    e.ovf  = ((f >> RES_W) != 0);
    e.n    = n;
    e.acc  = acc_cyc;
    sb.push_back(e);
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
    if (scramble) in_num = N_W'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: pops on each new result, checks hold stability while stalled.
  initial begin
    logic             prev_valid;
    logic [RES_W-1:0] held_fact;
    logic             held_ovf;
    exp_t             e;
    prev_valid = 1'b0;
    held_fact  = '0;
    held_ovf   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid) begin
          last_rise = cyc;
          if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = sb.pop_front();
            check($sformatf("fact_n%0d", e.n), out_fact, e.fact);
            check($sformatf("ovf_n%0d", e.n), out_ovf, e.ovf);
            check($sformatf("latency_n%0d", e.n), cyc - e.acc, (e.n < 2) ? 1 : e.n);
          end
          held_fact = out_fact;
          held_ovf  = out_ovf;
        end else if (out_valid && prev_valid) begin
          check("hold_fact", out_fact, held_fact);
          check("hold_ovf", out_ovf, held_ovf);
        end
        if (out_valid) begin
          check("in_ready_low_in_done", in_ready, 0);
          check("busy_in_done", busy, 1);
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, dummy;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_num   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_fact", out_fact, 1);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_busy", busy, 0);

    // Small operands, both single-cycle
    send(0, 0, 0, dummy);
    drain();
    send(1, 0, 0, dummy);
    drain();

    // n=5 with a 4-cycle output stall
    rdy_mode = 1;
    send(5, 0, 0, dummy);
    drain();
    repeat (4) @(negedge clk);
    check("stall_out_valid", out_valid, 1);
    check("stall_in_ready", in_ready, 0);
    rdy_mode = 0;

    // Overflow boundary
    send(12, 0, 0, dummy);
    drain();
    send(13, 0, 0, dummy);
    drain();
    send(15, 0, 0, dummy);
    drain();

    // Back-to-back with in_valid held, operand changed during CALC
    send(3, 0, 1, a1);
    send(4, 1, 0, a2);
    check("b2b_spacing", a2, last_rise + 2);
    drain();

    // Reset in the middle of a long computation
    send(10, 0, 0, dummy);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_fact", out_fact, 1);
    check("midrst_out_ovf", out_ovf, 0);
    send(4, 0, 0, dummy);
    drain();

    // Random operands, random output back-pressure, scrambled in_num after accept
    rdy_mode = 2;
    for (int k = 0; k < 40; k++) begin
      send(int'($urandom_range(0, (1 << N_W) - 1)), 1, 0, dummy);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    rdy_mode = 0;
    repeat (5) @(negedge clk);
    check("idle_at_end", in_ready, 1);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
